key_scan_ctrl: RTL and testbench

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl_pkg.sv | 17 +
 rtl/key_scan_ctrl_line_prescaler.sv | 32 +++
 rtl/key_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_key_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_ctrl_pkg.sv
// rtl/key_scan_ctrl_pkg.sv - shared POKEY keyboard scan types and scan indices
package key_scan_ctrl_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } scan_state_t;

  // Scan counter values at which the kr2 modifier line is meaningful
  localparam logic [5:0] SHIFT_IDX = 6'h10;
  localparam logic [5:0] CTRL_IDX  = 6'h20;
  localparam logic [5:0] BREAK_IDX = 6'h30;

endpackage

// File: rtl/key_scan_ctrl_line_prescaler.sv
// rtl/key_scan_ctrl_line_prescaler.sv - o2 divider producing one tick per scan line
module line_prescaler #(
  parameter int DIV = 114
) (
  input  logic o2,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Tick is the cycle in which the count wraps from DIV-1 back to 0
  assign tick = en && (count == LAST);

  // Free-running 0..DIV-1 counter, parked at 0 while scanning is disabled
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - keyboard matrix scanner with debounce and modifier sampling
module key_scan_ctrl
  import key_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 114
) (
  input  logic       o2,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       kr1_L,
  input  logic       kr2_L,
  input  logic       irq_ack,
  output logic [5:0] key_scan_L,
  output logic [7:0] kbcode,
  output logic       key_down,
  output logic       shift_down,
  output logic       key_irq,
  output logic       break_irq
);

  logic        tick;
  logic [5:0]  counter;
  logic [5:0]  compare_latch;
  logic        ctrl_sample;
  logic        hit;
  logic        key_set;
  logic        brk_set;
  scan_state_t state;

  line_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .o2   (o2),
    .rst  (rst),
    .en   (scan_en),
    .tick (tick)
  );

  assign key_scan_L = ~counter;
  assign hit        = (counter == compare_latch);
  assign key_set    = tick && (state == ST_CHECK) && hit && !kr1_L;
  assign brk_set    = tick && (counter == BREAK_IDX) && !kr2_L;

  // Scan line counter advances once per tick and wraps 63 -> 0
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (!scan_en) begin
      counter <= '0;
    end else if (tick) begin
      counter <= counter + 6'd1;
    end
  end

  // Debounce FSM: a key must be seen on two consecutive passes to be reported
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      compare_latch <= '0;
      kbcode        <= '0;
      key_down      <= 1'b0;
    end else if (!scan_en) begin
      state    <= ST_IDLE;
      key_down <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!kr1_L) begin
            compare_latch <= counter;
            state         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (hit) begin
            if (!kr1_L) begin
              kbcode   <= {ctrl_sample, shift_down, compare_latch};
              state    <= ST_HELD;
              key_down <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HELD: begin
          if (hit && kr1_L) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (hit) begin
            if (!kr1_L) begin
              state <= ST_HELD;
            end else begin
              state    <= ST_IDLE;
              key_down <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          key_down <= 1'b0;
        end
      endcase
    end
  end

  // Modifier samples taken when the scan reaches the shift and ctrl lines
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      shift_down  <= 1'b0;
      ctrl_sample <= 1'b0;
    end else if (tick) begin
      if (counter == SHIFT_IDX) begin
        shift_down <= ~kr2_L;
      end
      if (counter == CTRL_IDX) begin
        ctrl_sample <= ~kr2_L;
      end
    end
  end

  // Sticky interrupt flags; a set event overrides a simultaneous acknowledge
  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      key_irq   <= 1'b0;
      break_irq <= 1'b0;
    end else if (scan_en) begin
      key_irq   <= key_set | (key_irq & ~irq_ack);
      break_irq <= brk_set | (break_irq & ~irq_ack);
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb/tb_key_scan_ctrl.sv - scoreboard bench for key_scan_ctrl with a virtual keyboard
module tb_key_scan_ctrl;

  localparam int DIV  = 4;
  localparam int PASS = 64 * DIV;

  logic       o2 = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       kr1_L;
  logic       kr2_L;
  logic       irq_ack;
  logic [5:0] key_scan_L;
  logic [7:0] kbcode;
  logic       key_down;
  logic       shift_down;
  logic       key_irq;
  logic       break_irq;

  logic       key_pressed = 1'b0;
  logic [5:0] key_idx     = 6'h00;
  logic       shift_m     = 1'b0;
  logic       ctrl_m      = 1'b0;
  logic       brk_m       = 1'b0;
  logic [5:0] scan_idx;
  logic       mon_prev    = 1'b0;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] kb_model    = 8'h00;

  key_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .o2         (o2),
    .rst        (rst),
    .scan_en    (scan_en),
    .kr1_L      (kr1_L),
    .kr2_L      (kr2_L),
    .irq_ack    (irq_ack),
    .key_scan_L (key_scan_L),
    .kbcode     (kbcode),
    .key_down   (key_down),
    .shift_down (shift_down),
    .key_irq    (key_irq),
    .break_irq  (break_irq)
  );

  always #5 o2 = ~o2;

  // Virtual keyboard matrix: return lines pulled low when the addressed key is down
  assign scan_idx = ~key_scan_L;
  assign kr1_L = ~(key_pressed && (scan_idx == key_idx));
  assign kr2_L = ~(((scan_idx == 6'h10) && shift_m) ||
                   ((scan_idx == 6'h20) && ctrl_m)  ||
                   ((scan_idx == 6'h30) && brk_m));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge o2);
  endtask

  task automatic press(input logic [5:0] k, input int passes);
    key_idx     = k;
    key_pressed = 1'b1;
    cycles(passes * PASS);
  endtask

  task automatic release_key(input int passes);
    key_pressed = 1'b0;
    cycles(passes * PASS);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cycles(1);
    irq_ack = 1'b0;
  endtask

  // One keystroke: modifiers settle for a pass, key held n passes, then released
  task automatic key_txn(input logic [5:0] k, input int n, input logic sh, input logic ct);
    shift_m = sh;
    ctrl_m  = ct;
    cycles(PASS);
    check("shift_sample", {7'b0, shift_down}, {7'b0, sh});
    if (n >= 2) begin
      kb_model = {ct, sh, k};
      exp_q.push_back(kb_model);
    end
    press(k, n);
    check("key_down_held", {7'b0, key_down}, {7'b0, (n >= 2)});
    release_key(2);
    cycles(4);
    check("key_down_released", {7'b0, key_down}, 8'h00);
    check("kbcode_after", kbcode, kb_model);
    ack();
  endtask

  // Monitor: every new key interrupt must match the next expected keystroke
  initial begin
    forever begin
      @(negedge o2);
      if (key_irq === 1'b1 && !mon_prev) begin
        if (exp_q.size() == 0) check("unexpected_key_irq", {7'b0, key_irq}, 8'h00);
        else check("kbcode_on_irq", kbcode, exp_q.pop_front());
      end
      mon_prev = key_irq;
    end
  end

  initial begin
    int guard;
    logic [5:0] rk;
    int rn;
    logic rs;
    logic rc;

    rst     = 1'b1;
    scan_en = 1'b1;
    irq_ack = 1'b0;
    cycles(3);
    check("rst_key_scan_L", {2'b0, key_scan_L}, 8'h3F);
    check("rst_kbcode", kbcode, 8'h00);
    check("rst_key_down", {7'b0, key_down}, 8'h00);
    check("rst_key_irq", {7'b0, key_irq}, 8'h00);
    check("rst_break_irq", {7'b0, break_irq}, 8'h00);
    check("rst_shift_down", {7'b0, shift_down}, 8'h00);
    rst = 1'b0;
    cycles(DIV - 1);
    check("before_first_tick", {2'b0, key_scan_L}, 8'h3F);
    cycles(1);
    check("first_tick", {2'b0, key_scan_L}, 8'h3E);

    // Debounced key, then a single-pass bounce that must be ignored
    key_txn(6'h2A, 2, 1'b0, 1'b0);
    key_txn(6'h15, 1, 1'b0, 1'b0);

    // Repeat press during release: stays down, no new interrupt
    shift_m  = 1'b0;
    ctrl_m   = 1'b0;
    kb_model = 8'h05;
    exp_q.push_back(kb_model);
    press(6'h05, 2);
    check("repeat_key_down", {7'b0, key_down}, 8'h01);
    ack();
    release_key(1);
    check("release_one_pass", {7'b0, key_down}, 8'h01);
    press(6'h05, 1);
    check("repress_key_down", {7'b0, key_down}, 8'h01);
    check("repress_no_irq", {7'b0, key_irq}, 8'h00);
    release_key(2);
    cycles(4);
    check("repeat_released", {7'b0, key_down}, 8'h00);

    // Shift and ctrl both held
    key_txn(6'h01, 2, 1'b1, 1'b1);
    check("mod_kbcode", kbcode, 8'hC1);

    // Break with a coincident acknowledge, then a lone acknowledge
    shift_m = 1'b0;
    ctrl_m  = 1'b0;
    brk_m   = 1'b1;
    guard   = 0;
    while (scan_idx != 6'h30 && guard < 2 * PASS) begin
      cycles(1);
      guard++;
    end
    check("break_line_reached", {2'b0, scan_idx}, 8'h30);
    irq_ack = 1'b1;
    guard   = 0;
    while (scan_idx == 6'h30 && guard < 4 * DIV) begin
      cycles(1);
      guard++;
    end
    irq_ack = 1'b0;
    brk_m   = 1'b0;
    cycles(2);
    check("break_set_wins", {7'b0, break_irq}, 8'h01);
    ack();
    check("break_cleared", {7'b0, break_irq}, 8'h00);

    // Reset while the key is still being checked
    cycles(PASS);
    press(6'h33, 1);
    rst = 1'b1;
    cycles(2);
    key_pressed = 1'b0;
    kb_model    = 8'h00;
    check("rst_check_scan_L", {2'b0, key_scan_L}, 8'h3F);
    check("rst_check_key_down", {7'b0, key_down}, 8'h00);
    check("rst_check_kbcode", kbcode, 8'h00);
    rst = 1'b0;
    release_key(2);
    check("rst_check_no_irq", {7'b0, key_irq}, 8'h00);

    // Scan disable while a key is held
    kb_model = 8'h27;
    exp_q.push_back(kb_model);
    press(6'h27, 2);
    check("en_held_key_down", {7'b0, key_down}, 8'h01);
    scan_en = 1'b0;
    cycles(3);
    check("dis_scan_L", {2'b0, key_scan_L}, 8'h3F);
    check("dis_key_down", {7'b0, key_down}, 8'h00);
    check("dis_kbcode_hold", kbcode, 8'h27);
    check("dis_irq_hold", {7'b0, key_irq}, 8'h01);
    key_pressed = 1'b0;
    scan_en     = 1'b1;
    cycles(2 * PASS);
    check("reen_key_down", {7'b0, key_down}, 8'h00);
    ack();

    // Randomized keystrokes
    for (int i = 0; i < 10; i++) begin
      rk = 6'($urandom_range(0, 63));
      rn = $urandom_range(1, 3);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      key_txn(rk, rn, rs, rc);
    end

    cycles(8);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
